// File: rtl/mcycle_muldiv.sv
// mcycle_muldiv: multi-cycle RISC-V M-extension multiply/divide unit.
// One operation per Start pulse. Each operation runs a fixed WIDTH iterations,
// resolving one bit per clock.
// Handshake: Start is sampled only while idle. Busy is high from the accepting
// edge to the final edge. Done pulses for one cycle when Result1/Result2 update.
// Flush aborts an operation in flight and produces no Done.
module mcycle_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             Start,
   input  logic             Flush,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done,
   output logic             state_dbg
);

   typedef enum logic {IDLE = 1'b0, COMPUTE = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state, state_nxt;
   logic               start_acc, last_iter;
   logic [CNT_W-1:0]   cnt;
   logic               is_div, neg_res, neg_rem, div0, ovf;
   logic [WIDTH-1:0]   x, y, orig_op1;
   logic [2*WIDTH-1:0] acc, acc_nxt, prod;
   logic [WIDTH:0]     rem, rem_sh, rem_diff, rem_nxt, mul_sum;
   logic [WIDTH-1:0]   y_div_nxt, quo, rmd, fin1, fin2;
   logic               in_signed, op1_neg, op2_neg;
   logic [WIDTH-1:0]   op1_mag, op2_mag;

   assign state_dbg = state;

   // State register.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state; Flush beats a completing iteration, Start beats Flush in IDLE.
   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      last_iter = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               start_acc = 1'b1;
               state_nxt = COMPUTE;
            end
         end
         COMPUTE: begin
            if (Flush) begin
               state_nxt = IDLE;
            end else if (cnt == LAST) begin
               last_iter = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand magnitudes and sign decoding at acceptance (op bit 0 = unsigned).
   always_comb begin
      in_signed = ~MCycleOp[0];
      op1_neg   = in_signed & Operand1[WIDTH-1];
      op2_neg   = in_signed & Operand2[WIDTH-1];
      op1_mag   = op1_neg ? -Operand1 : Operand1;
      op2_mag   = op2_neg ? -Operand2 : Operand2;
   end

   // One iteration of shift-add multiply and restoring divide, plus final values.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (y[0] ? x : '0)};
      acc_nxt   = {mul_sum, acc[WIDTH-1:1]};
      rem_sh    = {rem[WIDTH-1:0], y[WIDTH-1]};
      rem_diff  = rem_sh - {1'b0, x};
      rem_nxt   = rem_diff[WIDTH] ? rem_sh : rem_diff;
      y_div_nxt = {y[WIDTH-2:0], ~rem_diff[WIDTH]};
      prod      = neg_res ? -acc_nxt : acc_nxt;
      quo       = neg_res ? -y_div_nxt : y_div_nxt;
      rmd       = neg_rem ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
      fin1      = prod[WIDTH-1:0];
      fin2      = prod[2*WIDTH-1:WIDTH];
      if (is_div) begin
         if (div0) begin
            fin1 = '1;
            fin2 = orig_op1;
         end else if (ovf) begin
            fin1 = MOST_NEG;
            fin2 = '0;
         end else begin
            fin1 = quo;
            fin2 = rmd;
         end
      end
   end

   // Datapath registers: latch at acceptance, iterate in COMPUTE, load results on the last edge.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div0     <= 1'b0;
         ovf      <= 1'b0;
         x        <= '0;
         y        <= '0;
         orig_op1 <= '0;
         acc      <= '0;
         rem      <= '0;
         Result1  <= '0;
         Result2  <= '0;
      end else if (start_acc) begin
         cnt      <= '0;
         is_div   <= MCycleOp[1];
         neg_res  <= op1_neg ^ op2_neg;
         neg_rem  <= op1_neg;
         div0     <= (Operand2 == '0);
         ovf      <= in_signed & (Operand1 == MOST_NEG) & (Operand2 == '1);
         x        <= op2_mag;
         y        <= op1_mag;
         orig_op1 <= Operand1;
         acc      <= '0;
         rem      <= '0;
      end else if (state == COMPUTE && !Flush) begin
         cnt <= cnt + 1'b1;
         if (is_div) begin
            y   <= y_div_nxt;
            rem <= rem_nxt;
         end else begin
            y   <= y >> 1;
            acc <= acc_nxt;
         end
         if (last_iter) begin
            Result1 <= fin1;
            Result2 <= fin2;
         end
      end
   end

   // Registered status outputs.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         Busy <= 1'b0;
         Done <= 1'b0;
      end else begin
         Busy <= (state_nxt == COMPUTE);
         Done <= last_iter;
      end
   end

endmodule
